multiport_register_file: RTL and testbench

Parametrised general-purpose register file for the RISC-V datapath, successor to the single-write, dual-read wrapper register file. It provides NUM_RD asynchronous read ports, two synchronous write ports with fixed priority, optional write-to-read bypass, and a per-register pending scoreboard. The scoreboard lets a pipelined decode stage detect read-after-write hazards on registers with outstanding writes.

---
 rtl/multiport_register_file_pkg.sv | 32 +++
 rtl/multiport_register_file_if.sv | 43 ++++
 rtl/multiport_register_file_scoreboard.sv | 52 +++++
 rtl/multiport_register_file.sv | 94 +++++++++
 tb/tb_multiport_register_file.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/multiport_register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
// This package holds the definitions shared by the multiport register file.
//   - Default WIDTH and SIZE parameter values.
//   - ZERO_REG, the hardwired-zero register index.
//   - The address typedef.
//   - The bypass-mux select encoding, plus the function that computes it.
// ----------------------------------------------------------------------------
package register_file_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int SIZE_DEFAULT  = 5;
  localparam int ZERO_REG      = 0;

  typedef logic [SIZE_DEFAULT-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SEL_STORED = 2'd0,
    SEL_WD0    = 2'd1,
    SEL_WD1    = 2'd2
  } bypass_sel_e;

  // hit0/hit1 are asserted when write port 0/1 targets the same nonzero
  // address as the read this cycle. Port 1 wins because it also wins storage.
  function automatic bypass_sel_e bypass_select(input logic hit0,
                                                input logic hit1);
    if (hit1)      return SEL_WD1;
    else if (hit0) return SEL_WD0;
    else           return SEL_STORED;
  endfunction

endpackage

// File: rtl/multiport_register_file_if.sv
// ----------------------------------------------------------------------------
// multiport_register_file_if
// This interface carries the bus of the multiport register file.
//   - Two write ports.
//   - Packed read addresses, read data and read pending bits.
//   - The scoreboard issue request and any_pending.
// master: the datapath side, which drives the requests.
// slave:  the register file itself.
// ----------------------------------------------------------------------------
interface multiport_register_file_if #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 5,
  parameter int NUM_RD = 2
);

  logic                     reg_write_we0_i;
  logic [SIZE-1:0]          write_register_a0_i;
  logic [WIDTH-1:0]         write_data_wd0_i;
  logic                     reg_write_we1_i;
  logic [SIZE-1:0]          write_register_a1_i;
  logic [WIDTH-1:0]         write_data_wd1_i;
  logic [NUM_RD*SIZE-1:0]   read_register_i;
  logic [NUM_RD*WIDTH-1:0]  read_data_o;
  logic [NUM_RD-1:0]        read_pending_o;
  logic                     issue_valid_i;
  logic [SIZE-1:0]          issue_rd_i;
  logic                     any_pending_o;

  modport master (
    output reg_write_we0_i, write_register_a0_i, write_data_wd0_i,
    output reg_write_we1_i, write_register_a1_i, write_data_wd1_i,
    output read_register_i, issue_valid_i, issue_rd_i,
    input  read_data_o, read_pending_o, any_pending_o
  );

  modport slave (
    input  reg_write_we0_i, write_register_a0_i, write_data_wd0_i,
    input  reg_write_we1_i, write_register_a1_i, write_data_wd1_i,
    input  read_register_i, issue_valid_i, issue_rd_i,
    output read_data_o, read_pending_o, any_pending_o
  );

endinterface

// File: rtl/multiport_register_file_scoreboard.sv
// ----------------------------------------------------------------------------
// register_scoreboard
// This module keeps one pending bit per register.
//   - A set marks the register as having an outstanding write.
//   - A clear, from either write port, retires that write.
//   - A set and a clear on the same register in the same cycle: the set wins,
//     because the issue belongs to a newer instruction.
//   - Register 0 is never pending.
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   set_en, set_addr           issue of a destination register
//   clr0_en/clr0_addr          accepted write on port 0
//   clr1_en/clr1_addr          accepted write on port 1
//   pending                    one bit per register
// ----------------------------------------------------------------------------
module register_scoreboard
  import register_file_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 set_en,
  input  logic [SIZE-1:0]      set_addr,
  input  logic                 clr0_en,
  input  logic [SIZE-1:0]      clr0_addr,
  input  logic                 clr1_en,
  input  logic [SIZE-1:0]      clr1_addr,
  output logic [2**SIZE-1:0]   pending
);

  logic [2**SIZE-1:0] pending_next;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_next = pending;
    if (clr0_en) pending_next[clr0_addr] = 1'b0;
    if (clr1_en) pending_next[clr1_addr] = 1'b0;
    // The set is applied after both clears, so it overrides them.
    if (set_en)  pending_next[set_addr]  = 1'b1;
    pending_next[ZERO_REG] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/multiport_register_file.sv
// ----------------------------------------------------------------------------
// multiport_register_file
// General-purpose register file with the following features.
//   - NUM_RD combinational read ports.
//   - Two write ports; port 1 has priority on an address collision.
//   - Optional same-cycle write-to-read bypass (BYPASS=1).
//   - A per-register pending scoreboard for read-after-write hazard detection.
//   - Register 0 reads as zero, ignores writes and is never pending.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; clears registers and pending bits
//   bus    multiport_register_file_if.slave (write ports, read ports, issue)
// ----------------------------------------------------------------------------
module multiport_register_file
  import register_file_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int SIZE   = SIZE_DEFAULT,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  multiport_register_file_if.slave    bus
);

  localparam int            NREGS = 2**SIZE;
  localparam logic [SIZE-1:0] ZERO_ADDR = SIZE'(ZERO_REG);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pending;

  logic wr0_ok;
  logic wr1_ok;

  assign wr0_ok = bus.reg_write_we0_i && (bus.write_register_a0_i != ZERO_ADDR);
  assign wr1_ok = bus.reg_write_we1_i && (bus.write_register_a1_i != ZERO_ADDR);

  // NOTE: the storage array is reset on purpose. Every register must read
  // zero during reset, so the array is built from resettable flops, not
  // inferred RAM.
  //
  // Port 1 is written second, so on an address collision its non-blocking
  // update is the one that lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs <= '{default: '0};
    end else begin
      if (wr0_ok) regs[bus.write_register_a0_i] <= bus.write_data_wd0_i;
      if (wr1_ok) regs[bus.write_register_a1_i] <= bus.write_data_wd1_i;
    end
  end

  register_scoreboard #(.SIZE(SIZE)) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_en    (bus.issue_valid_i && (bus.issue_rd_i != ZERO_ADDR)),
    .set_addr  (bus.issue_rd_i),
    .clr0_en   (wr0_ok),
    .clr0_addr (bus.write_register_a0_i),
    .clr1_en   (wr1_ok),
    .clr1_addr (bus.write_register_a1_i),
    .pending   (pending)
  );

  assign bus.any_pending_o = |pending;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [SIZE-1:0]  ra;
    logic             hit0;
    logic             hit1;
    logic [WIDTH-1:0] rdata;

    assign ra = bus.read_register_i[k*SIZE +: SIZE];

    // Forwarding is gated by reset, so a write that is being discarded by
    // reset is never forwarded to a read port.
    assign hit0 = BYPASS && reset && wr0_ok && (bus.write_register_a0_i == ra);
    assign hit1 = BYPASS && reset && wr1_ok && (bus.write_register_a1_i == ra);

    always_comb begin
      rdata = '0;
      unique case (bypass_select(hit0, hit1))
        SEL_WD1: rdata = bus.write_data_wd1_i;
        SEL_WD0: rdata = bus.write_data_wd0_i;
        default: rdata = (ra == ZERO_ADDR) ? '0 : regs[ra];
      endcase
    end

    assign bus.read_data_o[k*WIDTH +: WIDTH] = rdata;
    assign bus.read_pending_o[k]             = pending[ra];
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// ----------------------------------------------------------------------------
// tb_multiport_register_file
// Two register files are driven with identical stimulus: u_dut_byp
// (BYPASS=1) and u_dut_nob (BYPASS=0). Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_multiport_register_file;
  import register_file_pkg::*;

  localparam int WIDTH  = 32;
  localparam int SIZE   = 5;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  logic reset;

  logic              we0, we1, issue_v;
  reg_addr_t         a0, a1, issue_rd, rd0, rd1;
  logic [WIDTH-1:0]  wd0, wd1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multiport_register_file_if #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_RD(NUM_RD)) bus_byp ();
  multiport_register_file_if #(.WIDTH(WIDTH), .SIZE(SIZE), .NUM_RD(NUM_RD)) bus_nob ();

  assign bus_byp.reg_write_we0_i     = we0;
  assign bus_byp.write_register_a0_i = a0;
  assign bus_byp.write_data_wd0_i    = wd0;
  assign bus_byp.reg_write_we1_i     = we1;
  assign bus_byp.write_register_a1_i = a1;
  assign bus_byp.write_data_wd1_i    = wd1;
  assign bus_byp.read_register_i     = {rd1, rd0};
  assign bus_byp.issue_valid_i       = issue_v;
  assign bus_byp.issue_rd_i          = issue_rd;

  assign bus_nob.reg_write_we0_i     = we0;
  assign bus_nob.write_register_a0_i = a0;
  assign bus_nob.write_data_wd0_i    = wd0;
  assign bus_nob.reg_write_we1_i     = we1;
  assign bus_nob.write_register_a1_i = a1;
  assign bus_nob.write_data_wd1_i    = wd1;
  assign bus_nob.read_register_i     = {rd1, rd0};
  assign bus_nob.issue_valid_i       = issue_v;
  assign bus_nob.issue_rd_i          = issue_rd;

  multiport_register_file #(
    .WIDTH(WIDTH), .SIZE(SIZE), .NUM_RD(NUM_RD), .BYPASS(1'b1)
  ) u_dut_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_byp.slave)
  );

  multiport_register_file #(
    .WIDTH(WIDTH), .SIZE(SIZE), .NUM_RD(NUM_RD), .BYPASS(1'b0)
  ) u_dut_nob (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nob.slave)
  );

  wire [WIDTH-1:0] byp_d0 = bus_byp.read_data_o[0 +: WIDTH];
  wire [WIDTH-1:0] byp_d1 = bus_byp.read_data_o[WIDTH +: WIDTH];
  wire [WIDTH-1:0] nob_d0 = bus_nob.read_data_o[0 +: WIDTH];
  wire [WIDTH-1:0] nob_d1 = bus_nob.read_data_o[WIDTH +: WIDTH];
  wire             byp_p0 = bus_byp.read_pending_o[0];
  wire             byp_p1 = bus_byp.read_pending_o[1];
  wire             byp_any = bus_byp.any_pending_o;
  wire             nob_any = bus_nob.any_pending_o;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; a0 = '0; wd0 = '0;
    we1 = 1'b0; a1 = '0; wd1 = '0;
    issue_v = 1'b0; issue_rd = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    rd0 = 5'd5; rd1 = 5'd0;
    #3;
    check("reset_rd0",     byp_d0,  32'd0);
    check("reset_pend0",   {31'd0, byp_p0}, 32'd0);
    check("reset_any",     {31'd0, byp_any}, 32'd0);

    @(negedge clk); reset = 1'b1;

    // Write 3 to x0 and issue x0: nothing is stored, nothing goes pending.
    @(negedge clk);
    we0 = 1'b1; a0 = 5'd0; wd0 = 32'd3; issue_v = 1'b1; issue_rd = 5'd0;
    rd0 = 5'd0; rd1 = 5'd0;
    #1 check("x0_bypass",  byp_d0, 32'd0);
    @(negedge clk); idle();
    #1;
    check("x0_rd0",        byp_d0, 32'd0);
    check("x0_rd1",        byp_d1, 32'd0);
    check("x0_nob_rd0",    nob_d0, 32'd0);
    check("x0_pend",       {31'd0, byp_p0}, 32'd0);
    check("x0_any",        {31'd0, byp_any}, 32'd0);

    // Dual write to different addresses.
    @(negedge clk);
    we0 = 1'b1; a0 = 5'd2; wd0 = 32'd7; we1 = 1'b1; a1 = 5'd4; wd1 = 32'd20;
    rd0 = 5'd2; rd1 = 5'd4;
    #1 check("dual_nob_pre", nob_d0, 32'd0);
    @(negedge clk); idle();
    #1;
    check("dual_byp_x2",   byp_d0, 32'd7);
    check("dual_byp_x4",   byp_d1, 32'd20);
    check("dual_nob_x2",   nob_d0, 32'd7);
    check("dual_nob_x4",   nob_d1, 32'd20);

    // Both ports write x31: port 1 wins, both in storage and in bypass.
    @(negedge clk);
    we0 = 1'b1; a0 = 5'd31; wd0 = 32'd6; we1 = 1'b1; a1 = 5'd31; wd1 = 32'd78;
    rd0 = 5'd31; rd1 = 5'd2;
    #1;
    check("coll_byp_same", byp_d0, 32'd78);
    check("coll_nob_same", nob_d0, 32'd0);
    check("coll_byp_x2",   byp_d1, 32'd7);
    @(negedge clk); idle();
    #1;
    check("coll_byp_x31",  byp_d0, 32'd78);
    check("coll_nob_x31",  nob_d0, 32'd78);

    // Port-0-only bypass.
    @(negedge clk);
    we0 = 1'b1; a0 = 5'd5; wd0 = 32'd11; rd0 = 5'd5; rd1 = 5'd31;
    #1;
    check("p0_byp_x5",     byp_d0, 32'd11);
    check("p0_nob_x5",     nob_d0, 32'd0);
    check("p0_byp_x31",    byp_d1, 32'd78);

    // Issue x19: pending appears one cycle later.
    @(negedge clk); idle();
    issue_v = 1'b1; issue_rd = 5'd19; rd0 = 5'd19;
    #1;
    check("iss_pend_same", {31'd0, byp_p0}, 32'd0);
    check("iss_any_same",  {31'd0, byp_any}, 32'd0);
    @(negedge clk); idle();
    #1;
    check("iss_pend_next", {31'd0, byp_p0}, 32'd1);
    check("iss_any_next",  {31'd0, byp_any}, 32'd1);

    // Write x19=5 on port 1: the clear is not bypassed to read_pending_o.
    @(negedge clk);
    we1 = 1'b1; a1 = 5'd19; wd1 = 32'd5;
    #1;
    check("clr_pend_same", {31'd0, byp_p0}, 32'd1);
    check("clr_byp_data",  byp_d0, 32'd5);
    @(negedge clk); idle();
    #1;
    check("clr_pend_next", {31'd0, byp_p0}, 32'd0);
    check("clr_any_next",  {31'd0, byp_any}, 32'd0);
    check("clr_nob_data",  nob_d0, 32'd5);

    // Issue and write x19 in the same cycle: the set wins, data still updates.
    @(negedge clk);
    issue_v = 1'b1; issue_rd = 5'd19; we0 = 1'b1; a0 = 5'd19; wd0 = 32'd9;
    @(negedge clk); idle();
    issue_v = 1'b1; issue_rd = 5'd7; rd0 = 5'd19; rd1 = 5'd7;
    #1;
    check("sw_pend19",     {31'd0, byp_p0}, 32'd1);
    check("sw_nob_data",   nob_d0, 32'd9);
    @(negedge clk); idle();
    #1;
    check("sw_pend7",      {31'd0, byp_p1}, 32'd1);
    check("sw_any",        {31'd0, nob_any}, 32'd1);

    // Reset asserted mid-cycle, during a write to x2.
    we0 = 1'b1; a0 = 5'd2; wd0 = 32'd55; rd0 = 5'd19; rd1 = 5'd2;
    #1 check("mr_pre_byp",  byp_d1, 32'd55);
    #1 reset = 1'b0;
    #1;
    check("mr_rd19",       byp_d0, 32'd0);
    check("mr_rd2_byp",    byp_d1, 32'd0);
    check("mr_rd19_nob",   nob_d0, 32'd0);
    check("mr_pend19",     {31'd0, byp_p0}, 32'd0);
    check("mr_any",        {31'd0, byp_any}, 32'd0);

    // The write that overlapped reset is lost; storage stays cleared.
    @(negedge clk); reset = 1'b1; idle();
    rd0 = 5'd2; rd1 = 5'd4;
    #1;
    check("post_x2",       nob_d0, 32'd0);
    check("post_x4",       nob_d1, 32'd0);

    // The first write after reset release takes effect on the next edge.
    @(negedge clk);
    we0 = 1'b1; a0 = 5'd3; wd0 = 32'h0000_1234; rd0 = 5'd3;
    @(negedge clk); idle();
    #1 check("post_x3",    nob_d0, 32'h0000_1234);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
